// File: rtl/ingreso_clave_teclado_if.sv
// Keypad-side bundle: key strobes and alarm in, PIN and status out.
interface ingreso_clave_teclado_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    key_valid;
    logic [3:0]              key_code;
    logic                    alarm_blocked;
    logic [4*NUM_DIGITS-1:0] password_input;
    logic                    password_valid;
    logic                    entry_error;
    logic [2:0]              digit_count;
    logic                    keypad_locked;

    modport master (
        input  key_valid, key_code, alarm_blocked,
        output password_input, password_valid, entry_error,
        output digit_count, keypad_locked
    );

    modport slave (
        output key_valid, key_code, alarm_blocked,
        input  password_input, password_valid, entry_error,
        input  digit_count, keypad_locked
    );
endinterface

// File: rtl/ingreso_clave_teclado.sv
// Keypad PIN collector: buffers BCD digits, submits on ENTER,
// discards partial entries on timeout and locks out while alarmed.
module ingreso_clave_teclado #(
    parameter int NUM_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TO_W           = 10
) (
    input logic                     clk,
    input logic                     rst,
    ingreso_clave_teclado_if.master bus
);
    localparam int W = 4 * NUM_DIGITS;

    typedef enum logic [2:0] {
        IDLE, ENTRY, FULL, SEND, LOCKED
    } state_t;

    state_t          state, state_n;
    logic [W-1:0]    shreg, shreg_n;
    logic [W-1:0]    pin, pin_n;
    logic [2:0]      cnt, cnt_n;
    logic [TO_W-1:0] tmr, tmr_n;
    logic            valid, valid_n;
    logic            err, err_n;
    logic            lock, lock_n;

    logic is_digit, is_clear, is_enter;
    logic accepted, in_entry, timed_out, last_digit;

    assign is_digit   = bus.key_valid && (bus.key_code <= 4'd9);
    assign is_clear   = bus.key_valid && (bus.key_code == 4'hA);
    assign is_enter   = bus.key_valid && (bus.key_code == 4'hB);
    assign accepted   = is_digit || is_clear || is_enter;
    assign in_entry   = (state == ENTRY) || (state == FULL);
    assign timed_out  = in_entry && (tmr == TO_W'(TIMEOUT_CYCLES - 1));
    assign last_digit = (cnt + 3'd1) == 3'(NUM_DIGITS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            pin   <= '0;
            cnt   <= '0;
            tmr   <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
            lock  <= 1'b0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            pin   <= pin_n;
            cnt   <= cnt_n;
            tmr   <= tmr_n;
            valid <= valid_n;
            err   <= err_n;
            lock  <= lock_n;
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        pin_n   = pin;
        cnt_n   = cnt;
        tmr_n   = '0;
        valid_n = 1'b0;
        err_n   = 1'b0;
        if (bus.alarm_blocked) begin
            state_n = LOCKED;
            shreg_n = '0;
            cnt_n   = '0;
        end else if (timed_out) begin
            state_n = IDLE;
            shreg_n = '0;
            cnt_n   = '0;
            err_n   = 1'b1;
        end else begin
            // Reserved codes leave the idle timer running.
            if (in_entry)
                tmr_n = accepted ? '0 : tmr + TO_W'(1);
            unique case (state)
                IDLE, ENTRY: begin
                    if (is_digit) begin
                        shreg_n = {shreg[W-5:0], bus.key_code};
                        cnt_n   = cnt + 3'd1;
                        state_n = last_digit ? FULL : ENTRY;
                    end else if (is_clear) begin
                        shreg_n = '0;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else if (is_enter) begin
                        shreg_n = '0;
                        cnt_n   = '0;
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
                FULL: begin
                    if (is_digit) begin
                        err_n = 1'b1;
                    end else if (is_clear) begin
                        shreg_n = '0;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else if (is_enter) begin
                        pin_n   = shreg;
                        valid_n = 1'b1;
                        state_n = SEND;
                    end
                end
                SEND: begin
                    shreg_n = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
                LOCKED: state_n = IDLE;
                default: begin
                    shreg_n = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            endcase
        end
        lock_n = (state_n == LOCKED);
    end

    assign bus.password_input = pin;
    assign bus.password_valid = valid;
    assign bus.entry_error    = err;
    assign bus.digit_count    = cnt;
    assign bus.keypad_locked  = lock;
endmodule
